// File: rtl/pll_reset_sequencer_pkg.sv
// State encoding and counter sizing shared by the PLL reset sequencer and its users.
package pll_reset_sequencer_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } seq_state_t;

   // Bits needed for a counter that must hold values 0 .. max(a,b,c,d)-1.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// N-flop single-bit synchroniser, async active-high reset; latency STAGES cycles, no flow control.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds PLLs in reset, qualifies lock stability, then releases downstream resets in order.
// All outputs registered; lock_in reaches the FSM after SYNC_STAGES cycles; no flow control.
module pll_reset_sequencer
   import pll_reset_sequencer_pkg::*;
#(
   parameter int NUM_LOCKS           = 2,
   parameter int NUM_STAGES          = 3,
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RESET_CYCLES    = 64,
   parameter int LOCK_TIMEOUT_CYCLES = 27000,
   parameter int STABLE_CYCLES       = 27000,
   parameter int STAGE_GAP_CYCLES    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_LOCKS-1:0]  lock_in,
   output logic                  pll_reset,
   output logic [NUM_STAGES-1:0] stage_reset,
   output logic                  ready,
   output logic [7:0]            retry_count,
   output logic [7:0]            lost_count
);

   localparam int CW = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES,
                                 (NUM_STAGES - 1) * STAGE_GAP_CYCLES + 1);
   localparam logic [CW-1:0] L_PLL_LAST = CW'(PLL_RESET_CYCLES - 1);
   localparam logic [CW-1:0] L_TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] L_STB_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] L_REL_LAST = CW'((NUM_STAGES - 1) * STAGE_GAP_CYCLES);

   logic [NUM_LOCKS-1:0]  w_lock_sync;
   logic                  w_locks_ok;

   seq_state_t            r_state;
   seq_state_t            w_next_state;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_inc;
   logic [CW-1:0]         w_next_cnt;
   logic                  w_retry_evt;
   logic                  w_lost_evt;

   logic                  r_pll_reset;
   logic [NUM_STAGES-1:0] r_stage_reset;
   logic                  r_ready;
   logic [7:0]            r_retry_count;
   logic [7:0]            r_lost_count;
   logic                  w_pll_reset_nxt;
   logic [NUM_STAGES-1:0] w_stage_reset_nxt;
   logic                  w_ready_nxt;
   logic [7:0]            w_retry_count_nxt;
   logic [7:0]            w_lost_count_nxt;

   for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_lock_sync
      sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
         .i_clk (clk),
         .i_rst (reset),
         .i_d   (lock_in[g]),
         .o_q   (w_lock_sync[g])
      );
   end

   assign w_locks_ok = &w_lock_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= PLL_RST;
         r_cnt         <= '0;
         r_pll_reset   <= 1'b1;
         r_stage_reset <= '1;
         r_ready       <= 1'b0;
         r_retry_count <= '0;
         r_lost_count  <= '0;
      end else begin
         r_state       <= w_next_state;
         r_cnt         <= w_next_cnt;
         r_pll_reset   <= w_pll_reset_nxt;
         r_stage_reset <= w_stage_reset_nxt;
         r_ready       <= w_ready_nxt;
         r_retry_count <= w_retry_count_nxt;
         r_lost_count  <= w_lost_count_nxt;
      end
   end

   // Lock loss is tested first so it always beats a coincident timeout or release.
   always_comb begin
      w_next_state = r_state;
      w_cnt_inc    = r_cnt + 1'b1;
      w_retry_evt  = 1'b0;
      w_lost_evt   = 1'b0;
      unique case (r_state)
         PLL_RST: begin
            if (r_cnt == L_PLL_LAST) w_next_state = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (w_locks_ok) begin
               w_next_state = STABLE;
            end else if (r_cnt == L_TMO_LAST) begin
               w_next_state = PLL_RST;
               w_retry_evt  = 1'b1;
            end
         end
         STABLE: begin
            if (!w_locks_ok) begin
               w_next_state = WAIT_LOCK;
            end else if (r_cnt == L_STB_LAST) begin
               w_next_state = (NUM_STAGES == 1) ? RUN : RELEASE;
            end
         end
         RELEASE: begin
            if (!w_locks_ok) begin
               w_next_state = WAIT_LOCK;
               w_lost_evt   = 1'b1;
            end else if (w_cnt_inc == L_REL_LAST) begin
               w_next_state = RUN;
            end
         end
         RUN: begin
            if (!w_locks_ok) begin
               w_next_state = WAIT_LOCK;
               w_lost_evt   = 1'b1;
            end
         end
         default: w_next_state = PLL_RST;
      endcase

      if (w_next_state != r_state) w_next_cnt = '0;
      else if (r_state == RUN)     w_next_cnt = r_cnt;
      else                         w_next_cnt = w_cnt_inc;
   end

   // Outputs are decoded from the next state/count so each register lands on the transition edge.
   always_comb begin
      w_pll_reset_nxt   = (w_next_state == PLL_RST);
      w_ready_nxt       = (w_next_state == RUN);
      w_stage_reset_nxt = r_stage_reset;
      if (w_next_state == RUN) begin
         w_stage_reset_nxt = '0;
      end else if (w_next_state == RELEASE) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (w_next_cnt == CW'(k * STAGE_GAP_CYCLES)) w_stage_reset_nxt[k] = 1'b0;
         end
      end else begin
         w_stage_reset_nxt = '1;
      end

      w_retry_count_nxt = r_retry_count;
      if (w_retry_evt && (r_retry_count != 8'hFF)) w_retry_count_nxt = r_retry_count + 8'd1;
      w_lost_count_nxt = r_lost_count;
      if (w_lost_evt && (r_lost_count != 8'hFF)) w_lost_count_nxt = r_lost_count + 8'd1;
   end

   assign pll_reset   = r_pll_reset;
   assign stage_reset = r_stage_reset;
   assign ready       = r_ready;
   assign retry_count = r_retry_count;
   assign lost_count  = r_lost_count;

endmodule
